// File: rtl/sha_message_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63] and streams one word per clock.
// state | meaning
// IDLE  | no block in flight, ready for a new block
// RUN   | emitting W[t]; ready again while W[63] is on the output
module sha_message_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] block_i,
  input  logic         block_valid_i,
  output logic         block_ready_o,
  output logic [31:0]  W_o,
  output logic         valid_o,
  output logic         newblock_o,
  output logic         last_o,
  output logic [5:0]   round_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [31:0] cur [16];
  logic [31:0] w_new;
  logic [5:0]  t;
  logic        accept;
  logic        emit;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign block_ready_o = (state == IDLE) || last_o;
  assign accept        = block_valid_i && block_ready_o;

  // A back-to-back accept feeds the fresh block straight into the emit path so W[0] follows W[63].
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cur[i] = accept ? block_i[511-32*i -: 32] : win[i];
    end
    w_new = sig1(cur[14]) + cur[9] + sig0(cur[1]) + cur[0];
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        emit = !last_o || accept;
        if (last_o && !accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // t is the index of the next word to emit; it wraps 63->0 so a reload starts at round 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      W_o        <= '0;
      valid_o    <= 1'b0;
      newblock_o <= 1'b0;
      last_o     <= 1'b0;
      round_o    <= '0;
      t          <= '0;
    end else begin
      valid_o    <= 1'b0;
      newblock_o <= 1'b0;
      last_o     <= 1'b0;
      if (emit) begin
        for (int i = 0; i < 15; i++) win[i] <= cur[i+1];
        win[15]    <= w_new;
        W_o        <= cur[0];
        round_o    <= t;
        valid_o    <= 1'b1;
        newblock_o <= (t == 6'd0);
        last_o     <= (t == 6'd63);
        t          <= t + 6'd1;
      end else if (accept) begin
        for (int i = 0; i < 16; i++) win[i] <= cur[i];
        t <= '0;
      end
    end
  end

endmodule

// File: doc/sha_message_schedule.md
# sha_message_schedule

Generates the 64-word SHA-256 message schedule W[0..63] for one 512-bit block and streams it, one word per clock, into the super-pipelined round chain. Each emitted word carries a valid flag and a first-word marker that travel alongside the hash state through the round stages. The block sits at the head of the SHA core, between the block source and the first round stage. It is the producer of the W/valid/newblock stream that the round stages consume.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- block_i  in  512  message block; word 0 in bits [511:480], word 15 in bits [31:0] (big-endian SHA order).
- block_valid_i  in  1  block_i is valid this cycle.
- block_ready_o  out  1  block accepted on a cycle where block_valid_i && block_ready_o.
- W_o  out  32  schedule word for the current round.
- valid_o  out  1  W_o is valid.
- newblock_o  out  1  W_o is W[0] of a new block.
- last_o  out  1  W_o is W[63].
- round_o  out  6  index t of W_o.

## Operation
- Two states: IDLE, RUN.
  - IDLE: block_ready_o=1, valid_o=0.
  - Accept in IDLE: load the 16-word window from block_i, set t=0, go to RUN.
- RUN: each cycle, present W[t] registered, then advance t.
  - t<16: W[t] = word t of the loaded block.
  - t>=16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Window: 16x32 shift register, oldest word at index 0. Each RUN cycle shifts by one and appends the newly computed word.
- block_ready_o is 1 in IDLE, and in RUN only while W[63] is being presented (last_o=1).
- Back-to-back: an accept while last_o=1 reloads the window. W[0] of the new block follows W[63] with no bubble, and the state stays RUN.
- After W[63] with no accept: go to IDLE.
- newblock_o=1 exactly when round_o=0 and valid_o=1. last_o=1 exactly when round_o=63 and valid_o=1.
- There is no output backpressure. The round chain always advances, matching the ungated stage pipeline.
- block_valid_i while block_ready_o=0 is ignored. The source must hold it until accepted.

## Timing
- Reset values: valid_o=0, newblock_o=0, last_o=0, round_o=0, W_o=0, block_ready_o=1, state IDLE.
- Latency: block accepted at edge N gives W[0] valid after edge N+1, then one word per cycle. W[63] appears after edge N+64.
- Sustained throughput: one block per 64 cycles.
- rst mid-RUN: at the next edge, abandon the block, valid_o=0, return to IDLE. No partial words are emitted after reset.
- rst takes priority over a simultaneous accept. A block presented in the reset cycle is not taken.
- round_o wraps 63→0 only through a back-to-back accept. It never free-runs past 63.
- The σ computation and the 4-input add complete within one cycle, from the registered window to the W_o register.

## Test plan
- Reset, then all-zero block: W_o=0x00000000 for t=0..63.
  - newblock_o at t=0 only, last_o at t=63 only.
  - block_ready_o returns to 1 after t=63.
- "abc" padded block (word0=0x61626380, words 1..14=0, word15=0x00000018):
  - W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000.
  - All 64 words match a software model.
- Two blocks back-to-back, second offered during the first block's t=63 cycle:
  - 128 consecutive valid cycles, no bubble.
  - newblock_o high at cycles 1 and 65 after the first accept.
- block_valid_i held high during RUN (t=5..62): no accept and no disturbance to W_o. The block is accepted only at t=63.
- rst asserted at t=30: after the next edge valid_o=0 and block_ready_o=1. A subsequent block then restarts at t=0 with correct words.
- rst and block_valid_i asserted together in IDLE: no accept, and valid_o stays 0 on the following cycle.
